// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, register-index width
// and the bundle of per-stage enable/bubble strobes.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic flush_if;
    logic nop_id;
    logic stall_nop;
  } ctrl_t;

  // Strobes for a pipeline that is free to advance: a flush kills IF/ID and
  // wins over a load-use stall, since the stalled ID instruction dies anyway.
  function automatic ctrl_t resolve_ctrl(input logic flush, input logic load_use);
    ctrl_t c;
    c = '{pc_we: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1, ex_mem_we: 1'b1,
          mem_wb_we: 1'b1, flush_if: 1'b0, nop_id: 1'b0, stall_nop: 1'b0};
    if (flush) begin
      c.flush_if = 1'b1;
      c.nop_id   = 1'b1;
    end else if (load_use) begin
      c.pc_we     = 1'b0;
      c.if_id_we  = 1'b0;
      c.nop_id    = 1'b1;
      c.stall_nop = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1_ID,
  input  logic [REG_W-1:0] rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [REG_W-1:0] RegDest_EX,
  input  logic             MemRead_EX,
  output logic             load_use
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1  = use_rs1_ID && (rs1_ID == RegDest_EX);
  assign hit_rs2  = use_rs2_ID && (rs2_ID == RegDest_EX);
  // r0 is hardwired to zero, so a load targeting it never produces a dependency.
  assign load_use = MemRead_EX && (RegDest_EX != REG_ZERO) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: stage enables, bubbles and flushes for load-use,
// branch/jump, data-memory wait and halt. Define PIPE_PERF_CNT_EN for perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 8,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [REG_W-1:0] rs1_ID,
  input  logic [REG_W-1:0] rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [REG_W-1:0] RegDest_EX,
  input  logic             MemRead_EX,
  input  logic             is_taken_EX,
  input  logic             is_jmp_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             PC_WE,
  output logic             IF_ID_WE,
  output logic             ID_EX_WE,
  output logic             EX_MEM_WE,
  output logic             MEM_WB_WE,
  output logic             flush_IF,
  output logic             nop_ID,
  output logic             stall_nop_ID,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;
  logic       timeout_now;
  logic       load_use;
  logic       flush;
  logic       is_stall;
  logic       is_flush;
  ctrl_t      ctrl;

  load_use_detect u_load_use_detect (
    .rs1_ID     (rs1_ID),
    .rs2_ID     (rs2_ID),
    .use_rs1_ID (use_rs1_ID),
    .use_rs2_ID (use_rs2_ID),
    .RegDest_EX (RegDest_EX),
    .MemRead_EX (MemRead_EX),
    .load_use   (load_use)
  );

  assign flush = is_taken_EX || is_jmp_EX;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    timeout_d   = timeout_q;
    timeout_now = 1'b0;
    is_stall    = 1'b0;
    is_flush    = 1'b0;
    ctrl        = '0;
    unique case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (mem_req_MEM && !mem_ready) begin
          state_d = MEMWAIT;
          wait_d  = 8'd1;
        end else begin
          ctrl     = resolve_ctrl(flush, load_use);
          is_flush = flush;
          is_stall = !flush && load_use;
        end
      end
      MEMWAIT: begin
        // halt_req is deliberately not looked at until the access completes.
        if (mem_ready) begin
          ctrl     = resolve_ctrl(flush, load_use);
          is_flush = flush;
          is_stall = !flush && load_use;
          state_d  = RUN;
          wait_d   = 8'd0;
        end else if (wait_q == WAIT_MAX) begin
          timeout_now = 1'b1;
          timeout_d   = 1'b1;
          state_d     = HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      HALT: ;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= RUN;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Reset overrides the strobes directly so the pipeline is held the instant RSTn drops.
  assign PC_WE        = RSTn && ctrl.pc_we;
  assign IF_ID_WE     = RSTn && ctrl.if_id_we;
  assign ID_EX_WE     = RSTn && ctrl.id_ex_we;
  assign EX_MEM_WE    = RSTn && ctrl.ex_mem_we;
  assign MEM_WB_WE    = RSTn && ctrl.mem_wb_we;
  assign flush_IF     = !RSTn || ctrl.flush_if;
  assign nop_ID       = !RSTn || ctrl.nop_id;
  assign stall_nop_ID = RSTn && ctrl.stall_nop;
  assign halted       = (state_q == HALT);
  assign mem_timeout  = timeout_q || timeout_now;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

  // Saturating counters; HALT produces no events, so they freeze there naturally.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    memwait_cnt_d = memwait_cnt_q;
    if (is_stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (is_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    if ((state_q == MEMWAIT) && (memwait_cnt_q != '1))
      memwait_cnt_d = memwait_cnt_q + CNT_ONE;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = ^{is_stall, is_flush};

  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
  assign memwait_cnt = '0;
`endif

endmodule
